shifter8_seq: RTL and testbench
===============================

Name: shifter8_seq

Overview:
Sequencer that lets a requester shift an 8-bit value by an arbitrary amount using the 8-bit registered shifter, which moves at most 3 bit positions per cycle.
- Accepts one command per transaction on a valid/ready handshake.
- Loads the operand into the shifter, then issues chunked shift ops until the requested amount is consumed.
- Returns the shifter's registered output on a valid/ready result handshake.
- Sits between the requester and the shifter datapath, and is the only driver of the shifter's op/shamt/d_in.

Parameters:
AMT_W, 4, width of the requested shift amount (maximum amount 2^AMT_W-1).

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command (high only in IDLE)
cmd_op  in  2  00 LSL, 01 LSR, 10 ASR, 11 reserved
cmd_amt  in  AMT_W  total shift amount
cmd_data  in  8  operand
res_valid  out  1  result available
res_ready  in  1  requester accepts result
res_data  out  8  result, equal to sh_d_out
busy  out  1  high in any state other than IDLE
sh_op  out  3  shifter opcode
sh_shamt  out  2  shifter shift amount (0-3)
sh_d_in  out  8  shifter load data
sh_d_out  in  8  shifter registered output

Behaviour:
- Shifter op encoding: NOP 000, LOAD 001, LSL 010, LSR 011, ASR 100. The shifter applies the op at the next clk edge.
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE, remaining=0, latched op=LSL.
  - Outputs: sh_op=NOP, sh_shamt=0, sh_d_in=0, cmd_ready=1, res_valid=0, busy=0.
- FSM:
  - IDLE: cmd_ready=1, sh_op=NOP. On cmd_valid&cmd_ready, latch cmd_op/cmd_amt/cmd_data and go to LOAD.
  - LOAD (1 cycle): sh_op=LOAD, sh_d_in=latched data. Go to DONE if remaining==0 or op==11, else go to SHIFT.
  - SHIFT: sh_op=latched op (LSL/LSR/ASR), sh_shamt=min(remaining,3). Each cycle, remaining-=sh_shamt. Go to DONE when the chunk issued equals remaining.
  - DONE: sh_op=NOP, res_valid=1, res_data=sh_d_out. Hold until res_ready, then go to IDLE.
- Latency: with the command accepted on edge T, res_valid rises in the cycle after edge T+1+ceil(amt/3). Example: amt=0 gives res_valid one cycle after LOAD.
- Chunk order: all chunks are 3 except the last one, which is the remainder.
- Amounts ≥8: the shifter saturates naturally (LSL/LSR produce 0, ASR produces sign fill). The controller still issues every chunk.
- Reserved op 11: the result is cmd_data unchanged.
- cmd_valid while busy: ignored (cmd_ready=0), with no side effects.
- res_data is stable while res_valid=1, because the shifter sees NOP.
- No back-to-back bypass: at least one IDLE cycle separates transactions.

Optional Feature:
SHIFTER8_SEQ_CLAMP_EN
- Defined: on acceptance, the latched amount is min(cmd_amt, 8). Any amount ≥8 finishes in 3 SHIFT cycles (3,3,2) with an identical result.
- Undefined: the full cmd_amt is chunked as described above.
- Either way, the result must be identical for all inputs; only the latency differs.

Decomposition:
- Package shifter8_pkg:
  - shifter opcode constants (NOP/LOAD/LSL/LSR/ASR);
  - command op constants (CMD_LSL/CMD_LSR/CMD_ASR/CMD_RSV);
  - FSM state enum (IDLE/LOAD/SHIFT/DONE);
  - MAX_CHUNK=3.
- Single module; no sub-module is needed.
- Top-level integration: instantiates shifter8_seq beside the existing shifter8, and wires sh_* to the shifter's op/shamt/d_in/d_out.

Test Plan:
- LSL 0x81, amt 5 → chunks LSL3, LSL2; res_data 0x20; res_valid in cycle 4 after acceptance.
- ASR 0x90, amt 7 → chunks 3,3,1; res_data 0xFF.
- LSR 0xF0, amt 4 → chunks 3,1; res_data 0x0F; hold res_ready=0 for 3 cycles → res_valid and res_data stable at 0x0F.
- amt 0 and op 11 with data 0xA5 → no SHIFT cycles; res_data 0xA5; cmd_valid pulsed while busy is ignored.
- LSL 0xFF, amt 15 → res_data 0x00, with 5 SHIFT cycles when the macro is undefined and 3 SHIFT cycles (3,3,2) when SHIFTER8_SEQ_CLAMP_EN is defined.
- Assert reset during the second SHIFT cycle → immediately sh_op=NOP, busy=0, res_valid=0; a new command then completes correctly.

Source files
------------

// File: rtl/shifter8_seq_pkg.sv
// -----------------------------------------------------------------------------
// shifter8_pkg
// Shared constants for the shifter8 sequencer:
//   - shifter8 opcodes (what the controller drives on sh_op)
//   - requester command ops (what arrives on cmd_op)
//   - sequencer FSM state encodings
//   - MAX_CHUNK: the most bit positions shifter8 moves in one cycle
// Also provides cmd_to_sh_op(), which maps a command op to a shifter opcode.
// -----------------------------------------------------------------------------
package shifter8_pkg;

  // shifter8 opcodes
  localparam logic [2:0] SH_NOP  = 3'b000;
  localparam logic [2:0] SH_LOAD = 3'b001;
  localparam logic [2:0] SH_LSL  = 3'b010;
  localparam logic [2:0] SH_LSR  = 3'b011;
  localparam logic [2:0] SH_ASR  = 3'b100;

  // requester command ops
  localparam logic [1:0] CMD_LSL = 2'b00;
  localparam logic [1:0] CMD_LSR = 2'b01;
  localparam logic [1:0] CMD_ASR = 2'b10;
  localparam logic [1:0] CMD_RSV = 2'b11;

  // sequencer FSM states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_SHIFT = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam int MAX_CHUNK = 32'sd3;

  // Reserved ops map to NOP; the FSM never reaches SHIFT with one.
  function automatic logic [2:0] cmd_to_sh_op(input logic [1:0] op);
    logic [2:0] res;
    case (op)
      CMD_LSL: res = SH_LSL;
      CMD_LSR: res = SH_LSR;
      CMD_ASR: res = SH_ASR;
      default: res = SH_NOP;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/shifter8_seq_if.sv
// -----------------------------------------------------------------------------
// shifter8_seq_if
// Requester-side bus of the shifter8 sequencer: the command handshake
// (cmd_valid/cmd_ready with cmd_op/cmd_amt/cmd_data) and the result
// handshake (res_valid/res_ready with res_data).
//   master  : the requester (drives commands, accepts results)
//   slave   : the sequencer (accepts commands, returns results)
// Parameter AMT_W: width of cmd_amt.
// -----------------------------------------------------------------------------
interface shifter8_seq_if #(
  parameter int AMT_W = 4
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [AMT_W-1:0] cmd_amt;
  logic [7:0]       cmd_data;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;

  modport master (
    output cmd_valid, cmd_op, cmd_amt, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data
  );

endinterface

// File: rtl/shifter8_seq.sv
// -----------------------------------------------------------------------------
// shifter8_seq
// Sequencer that performs an arbitrary-amount 8-bit shift using the shifter8
// datapath, which moves at most MAX_CHUNK (3) positions per cycle. A command
// is latched in IDLE, the operand is loaded into the shifter, chunked shift
// ops are issued (3,3,...,remainder) and the shifter's registered output is
// handed back on the result handshake.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   reset     asynchronous, active-high reset
//   req       shifter8_seq_if.slave: cmd_* command handshake, res_* result
//   busy      high in every state except IDLE
//   sh_op     shifter opcode (NOP/LOAD/LSL/LSR/ASR)
//   sh_shamt  shifter shift amount, 0..3
//   sh_d_in   shifter load data
//   sh_d_out  shifter registered output (returned as res_data)
//
// Parameter AMT_W: width of the requested amount (max 2^AMT_W-1).
//
// Build option SHIFTER8_SEQ_CLAMP_EN: when defined, the latched amount is
// clamped to 8. An 8-bit shift by 8 or more already saturates, so the result
// is unchanged and only the number of SHIFT cycles drops.
// -----------------------------------------------------------------------------
module shifter8_seq
  import shifter8_pkg::*;
#(
  parameter int AMT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  shifter8_seq_if.slave       req,
  output logic                busy,
  output logic [2:0]          sh_op,
  output logic [1:0]          sh_shamt,
  output logic [7:0]          sh_d_in,
  input  logic [7:0]          sh_d_out
);

  // Size of the next shift chunk: MAX_CHUNK or the remainder, whichever is less.
  function automatic logic [1:0] chunk_of(input logic [AMT_W-1:0] rem);
    logic [1:0] res;
    if (int'(rem) > MAX_CHUNK) begin
      res = 2'(MAX_CHUNK);
    end else begin
      res = 2'(rem);
    end
    return res;
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic [AMT_W-1:0] rem_r;
  logic [AMT_W-1:0] rem_next_s;
  logic [1:0]       op_r;
  logic [1:0]       op_next_s;
  logic [7:0]       data_r;
  logic [7:0]       data_next_s;
  logic [AMT_W-1:0] amt_in_s;
  logic [1:0]       chunk_s;

  logic [2:0]       sh_op_s;
  logic [1:0]       sh_shamt_s;
  logic [7:0]       sh_d_in_s;

  logic [2:0]       sh_op_r;
  logic [1:0]       sh_shamt_r;
  logic [7:0]       sh_d_in_r;
  logic             cmd_ready_r;
  logic             res_valid_r;
  logic             busy_r;

  // Amount captured on acceptance, optionally clamped to 8.
  always_comb begin
`ifdef SHIFTER8_SEQ_CLAMP_EN
    if (int'(req.cmd_amt) > 32'sd8) begin
      amt_in_s = AMT_W'(8);
    end else begin
      amt_in_s = req.cmd_amt;
    end
`else
    amt_in_s = req.cmd_amt;
`endif
  end

  // Chunk issued in the current SHIFT cycle.
  always_comb begin
    chunk_s = chunk_of(rem_r);
  end

  // Next-state and command-latch logic.
  always_comb begin
    state_next_s = state_r;
    rem_next_s   = rem_r;
    op_next_s    = op_r;
    data_next_s  = data_r;
    case (state_r)
      ST_IDLE: begin
        if (req.cmd_valid) begin
          state_next_s = ST_LOAD;
          rem_next_s   = amt_in_s;
          op_next_s    = req.cmd_op;
          data_next_s  = req.cmd_data;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Reserved op returns the loaded operand untouched.
        if ((rem_r == {AMT_W{1'b0}}) || (op_r == CMD_RSV)) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        rem_next_s = rem_r - AMT_W'(chunk_s);
        if (AMT_W'(chunk_s) == rem_r) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (req.res_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Shifter controls for the state being entered; registered below so the
  // outputs line up with the state register.
  always_comb begin
    sh_op_s    = SH_NOP;
    sh_shamt_s = 2'd0;
    sh_d_in_s  = 8'd0;
    case (state_next_s)
      ST_LOAD: begin
        sh_op_s   = SH_LOAD;
        sh_d_in_s = data_next_s;
      end
      ST_SHIFT: begin
        sh_op_s    = cmd_to_sh_op(op_next_s);
        sh_shamt_s = chunk_of(rem_next_s);
      end
      default: begin
        sh_op_s = SH_NOP;
      end
    endcase
  end

  // FSM state and latched command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      rem_r   <= {AMT_W{1'b0}};
      op_r    <= CMD_LSL;
      data_r  <= 8'd0;
    end else begin
      state_r <= state_next_s;
      rem_r   <= rem_next_s;
      op_r    <= op_next_s;
      data_r  <= data_next_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_op_r     <= SH_NOP;
      sh_shamt_r  <= 2'd0;
      sh_d_in_r   <= 8'd0;
      cmd_ready_r <= 1'b1;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      sh_op_r     <= sh_op_s;
      sh_shamt_r  <= sh_shamt_s;
      sh_d_in_r   <= sh_d_in_s;
      cmd_ready_r <= (state_next_s == ST_IDLE);
      res_valid_r <= (state_next_s == ST_DONE);
      busy_r      <= (state_next_s != ST_IDLE);
    end
  end

  assign sh_op         = sh_op_r;
  assign sh_shamt      = sh_shamt_r;
  assign sh_d_in       = sh_d_in_r;
  assign busy          = busy_r;
  assign req.cmd_ready = cmd_ready_r;
  assign req.res_valid = res_valid_r;
  // Shifter sees NOP in DONE, so this is stable while res_valid is high.
  assign req.res_data  = sh_d_out;

endmodule

// File: tb/tb_shifter8_seq.sv
// -----------------------------------------------------------------------------
// tb_shifter8_seq
// Directed bench for shifter8_seq. A small behavioural shifter8 sits on the
// sh_* port. Inputs are driven and outputs sampled on the falling clock edge.
// Honours SHIFTER8_SEQ_CLAMP_EN for the expected SHIFT-cycle count.
// -----------------------------------------------------------------------------
module tb_shifter8_seq;
  import shifter8_pkg::*;

  localparam int AMT_W = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       busy;
  logic [2:0] sh_op;
  logic [1:0] sh_shamt;
  logic [7:0] sh_d_in;
  logic [7:0] sh_q_r;

  int tests_run = 0;
  int tests_failed = 0;

  shifter8_seq_if #(.AMT_W(AMT_W)) req_if ();

  always #5 clk = ~clk;

  // Behavioural shifter8: op applied at the rising edge.
  always_ff @(posedge clk) begin
    case (sh_op)
      SH_LOAD: sh_q_r <= sh_d_in;
      SH_LSL:  sh_q_r <= sh_q_r << sh_shamt;
      SH_LSR:  sh_q_r <= sh_q_r >> sh_shamt;
      SH_ASR:  sh_q_r <= 8'($signed(sh_q_r) >>> sh_shamt);
      default: sh_q_r <= sh_q_r;
    endcase
  end

  shifter8_seq #(.AMT_W(AMT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req_if),
    .busy     (busy),
    .sh_op    (sh_op),
    .sh_shamt (sh_shamt),
    .sh_d_in  (sh_d_in),
    .sh_d_out (sh_q_r)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full transaction. exp_shifts/exp_last describe the SHIFT cycles,
  // hold is how long res_ready stays low, poke pulses cmd_valid while busy.
  task automatic run_cmd(input string name, input logic [1:0] op, input logic [3:0] amt,
                         input logic [7:0] data, input logic [2:0] exp_op,
                         input logic [7:0] exp_data, input int exp_shifts,
                         input logic [1:0] exp_last, input int hold, input bit poke);
    int         n_shift;
    int         lat;
    bit         seen;
    logic [1:0] last;
    @(negedge clk);
    check({name, ":cmd_ready"}, req_if.cmd_ready, 1);
    req_if.cmd_op    = op;
    req_if.cmd_amt   = amt;
    req_if.cmd_data  = data;
    req_if.cmd_valid = 1'b1;
    @(negedge clk);
    req_if.cmd_valid = 1'b0;
    check({name, ":load_op"}, sh_op, SH_LOAD);
    check({name, ":load_data"}, sh_d_in, data);
    check({name, ":busy"}, busy, 1);
    if (poke) begin
      req_if.cmd_op    = CMD_LSL;
      req_if.cmd_amt   = 4'd1;
      req_if.cmd_data  = 8'h3C;
      req_if.cmd_valid = 1'b1;
    end
    n_shift = 0;
    lat     = 1;
    seen    = 1'b0;
    last    = 2'd0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      req_if.cmd_valid = 1'b0;
      lat++;
      if (req_if.res_valid) begin
        seen = 1'b1;
      end else if (sh_op != SH_NOP) begin
        check({name, ":shift_op"}, sh_op, exp_op);
        if (n_shift > 0) check({name, ":chunk"}, last, 2'd3);
        last = sh_shamt;
        n_shift++;
      end
    end
    check({name, ":res_seen"}, seen, 1);
    check({name, ":latency"}, lat, exp_shifts + 2);
    check({name, ":n_shift"}, n_shift, exp_shifts);
    if (exp_shifts > 0) check({name, ":last_chunk"}, last, exp_last);
    check({name, ":res_data"}, req_if.res_data, exp_data);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, ":hold_valid"}, req_if.res_valid, 1);
      check({name, ":hold_data"}, req_if.res_data, exp_data);
    end
    req_if.res_ready = 1'b1;
    @(negedge clk);
    req_if.res_ready = 1'b0;
    check({name, ":idle_valid"}, req_if.res_valid, 0);
    check({name, ":idle_ready"}, req_if.cmd_ready, 1);
    check({name, ":idle_busy"}, busy, 0);
  endtask

  initial begin
    int clamp_shifts;
    logic [1:0] clamp_last;
`ifdef SHIFTER8_SEQ_CLAMP_EN
    clamp_shifts = 3;
    clamp_last   = 2'd2;
`else
    clamp_shifts = 5;
    clamp_last   = 2'd3;
`endif
    req_if.cmd_valid = 1'b0;
    req_if.cmd_op    = 2'b00;
    req_if.cmd_amt   = 4'd0;
    req_if.cmd_data  = 8'd0;
    req_if.res_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst:sh_op", sh_op, SH_NOP);
    check("rst:sh_shamt", sh_shamt, 0);
    check("rst:sh_d_in", sh_d_in, 0);
    check("rst:cmd_ready", req_if.cmd_ready, 1);
    check("rst:res_valid", req_if.res_valid, 0);
    check("rst:busy", busy, 0);
    reset = 1'b0;

    run_cmd("lsl81_5",  CMD_LSL, 4'd5,  8'h81, SH_LSL, 8'h20, 2, 2'd2, 0, 1'b0);
    run_cmd("asr90_7",  CMD_ASR, 4'd7,  8'h90, SH_ASR, 8'hFF, 3, 2'd1, 0, 1'b0);
    run_cmd("lsrF0_4",  CMD_LSR, 4'd4,  8'hF0, SH_LSR, 8'h0F, 2, 2'd1, 3, 1'b0);
    run_cmd("amt0_A5",  CMD_LSL, 4'd0,  8'hA5, SH_LSL, 8'hA5, 0, 2'd0, 1, 1'b1);
    run_cmd("rsv_A5",   CMD_RSV, 4'd5,  8'hA5, SH_NOP, 8'hA5, 0, 2'd0, 0, 1'b1);
    run_cmd("lslFF_15", CMD_LSL, 4'd15, 8'hFF, SH_LSL, 8'h00, clamp_shifts, clamp_last, 0, 1'b0);
    run_cmd("asr80_9",  CMD_ASR, 4'd9,  8'h80, SH_ASR, 8'hFF, 3, 2'd3, 0, 1'b0);

    // Reset during the second SHIFT cycle.
    @(negedge clk);
    req_if.cmd_op    = CMD_LSL;
    req_if.cmd_amt   = 4'd9;
    req_if.cmd_data  = 8'h01;
    req_if.cmd_valid = 1'b1;
    @(negedge clk);
    req_if.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid:shift_op", sh_op, SH_LSL);
    reset = 1'b1;
    #1;
    check("mid:sh_op", sh_op, SH_NOP);
    check("mid:busy", busy, 0);
    check("mid:res_valid", req_if.res_valid, 0);
    check("mid:cmd_ready", req_if.cmd_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    run_cmd("post_rst", CMD_LSR, 4'd3, 8'h80, SH_LSR, 8'h10, 1, 2'd3, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
